// File: rtl/psub_pkg.sv
// psub_pkg
//   Shared definitions for the sequential packed (lane-wise) add/subtract
//   unit psub_seq_16bit and its per-lane datapath addsub_4bit.
//   Contents:
//     LANES   - number of sub-word lanes in the 16-bit word
//     LANE_W  - width of one lane in bits
//     state_t - controller states (IDLE, RUN, DONE)
package psub_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/psub_seq_16bit_addsub.sv
// addsub_4bit
//   Combinational signed add/subtract of one lane with two's-complement
//   overflow detection. The result wraps modulo 2**W.
//   Ports:
//     A    in  [W-1:0]  minuend / augend (signed)
//     B    in  [W-1:0]  subtrahend / addend (signed)
//     sub  in  1        1 = A-B, 0 = A+B
//     Res  out [W-1:0]  wrapped result
//     Ovfl out 1        signed overflow of this lane
module addsub_4bit #(
    parameter int W = psub_pkg::LANE_W
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         sub,
    output logic [W-1:0] Res,
    output logic         Ovfl
);

    logic [W-1:0] b_eff;

    // Subtraction is A + ~B + 1, so the carry-in is simply the sub bit.
    assign b_eff = sub ? ~B : B;
    assign Res   = A + b_eff + W'(sub);

    // Overflow when both effective operands share a sign and the result's
    // sign differs. For subtraction b_eff carries the inverted sign of B, which
    // turns this into "signs of A and B differ and result sign differs from A".
    assign Ovfl = (A[W-1] == b_eff[W-1]) && (Res[W-1] != A[W-1]);

endmodule

// File: rtl/psub_seq_16bit.sv
// psub_seq_16bit
//   Sequential packed add/subtract: a 16-bit word is treated as LANES signed
//   lanes of LANE_W bits, and one lane is processed per clock through a single
//   shared addsub_4bit. Lanes never exchange carries or borrows.
//   Ports:
//     clk       in   1       clock, rising edge
//     rst       in   1       synchronous active-high reset
//     start     in   1       request a new operation (accepted in IDLE/DONE)
//     sub       in   1       1 = A-B per lane, 0 = A+B per lane
//     A         in   16      first operand lanes
//     B         in   16      second operand lanes
//     busy      out  1       high while lanes are being processed
//     done      out  1       one-cycle pulse, results valid
//     Diff      out  16      lane-wise result, lane i at [4i+3:4i]
//     lane_ovfl out  4       per-lane signed overflow
//     Error     out  1       OR of lane_ovfl
module psub_seq_16bit #(
    parameter int LANES  = psub_pkg::LANES,
    parameter int LANE_W = psub_pkg::LANE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic [LANES*LANE_W-1:0] A,
    input  logic [LANES*LANE_W-1:0] B,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*LANE_W-1:0] Diff,
    output logic [LANES-1:0]        lane_ovfl,
    output logic                    Error
);

    import psub_pkg::*;

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                    state;
    state_t                    next_state;
    logic                      accept;
    logic                      last_lane;
    logic [CW-1:0]             cnt;
    logic [LANES*LANE_W-1:0]   a_q;
    logic [LANES*LANE_W-1:0]   b_q;
    logic                      sub_q;
    logic [LANES*LANE_W-1:0]   diff_q;
    logic [LANES-1:0]          ovfl_q;
    logic [LANE_W-1:0]         lane_a;
    logic [LANE_W-1:0]         lane_b;
    logic [LANE_W-1:0]         lane_res;
    logic                      lane_ov;

    // Captured operands are muxed down to the lane selected by the counter,
    // so changes on A/B after acceptance never reach the datapath.
    assign lane_a    = a_q[cnt*LANE_W +: LANE_W];
    assign lane_b    = b_q[cnt*LANE_W +: LANE_W];
    assign last_lane = (cnt == CW'(LANES - 1));

    addsub_4bit #(
        .W(LANE_W)
    ) u_lane (
        .A   (lane_a),
        .B   (lane_b),
        .sub (sub_q),
        .Res (lane_res),
        .Ovfl(lane_ov)
    );

    // Next-state and status decode. Start is honoured only when no lane work
    // is in flight; from DONE it re-enters RUN directly for back-to-back use.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_lane) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, operand capture and per-lane result write-back. Results are only
    // touched on acceptance (cleared) or in RUN, so they stay stable through
    // DONE and IDLE until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            diff_q <= '0;
            ovfl_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_q    <= A;
                b_q    <= B;
                sub_q  <= sub;
                diff_q <= '0;
                ovfl_q <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                diff_q[cnt*LANE_W +: LANE_W] <= lane_res;
                ovfl_q[cnt]                  <= lane_ov;
                cnt                          <= cnt + 1'b1;
            end
        end
    end

    assign Diff      = diff_q;
    assign lane_ovfl = ovfl_q;
    assign Error     = |ovfl_q;

endmodule

// File: tb/tb_psub_seq_16bit.sv
// tb_psub_seq_16bit
//   Directed bench for psub_seq_16bit with a result scoreboard: every accepted
//   operation pushes its model result, every done pulse pops and compares.
module tb_psub_seq_16bit;

    typedef struct {
        logic [15:0] diff;
        logic [3:0]  ovfl;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic [3:0]  lane_ovfl;
    logic        Error;

    exp_t        sb[$];
    exp_t        lastExp;
    int          checks;
    int          passes;

    psub_seq_16bit #(
        .LANES (4),
        .LANE_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Diff     (Diff),
        .lane_ovfl(lane_ovfl),
        .Error    (Error)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: independent per-lane signed arithmetic on 4-bit lanes.
    function automatic exp_t model(input logic s, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [3:0]  ai;
        logic [3:0]  bi;
        logic [3:0]  r;
        e.diff = '0;
        e.ovfl = '0;
        for (int i = 0; i < 4; i++) begin
            ai = a[4*i +: 4];
            bi = b[4*i +: 4];
            r  = s ? (ai - bi) : (ai + bi);
            e.diff[4*i +: 4] = r;
            if (s)
                e.ovfl[i] = (ai[3] != bi[3]) && (r[3] != ai[3]);
            else
                e.ovfl[i] = (ai[3] == bi[3]) && (r[3] != ai[3]);
        end
        e.err = |e.ovfl;
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start request (edge N), push its model result, release start.
    task automatic applyStimulus(input logic s, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        A     = a;
        B     = b;
        sb.push_back(model(s, a, b));
        tick();
        start = 1'b0;
        check("busy_after_start", 16'(busy), 16'd1);
    endtask

    // Bounded wait for done; returns the number of edges waited.
    task automatic waitDone(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("done_seen", 16'(done), 16'd1);
    endtask

    // Pop the scoreboard and compare the visible results.
    task automatic checkOutput(input string tag);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 16'(sb.size()), 16'd1);
        end else begin
            lastExp = sb.pop_front();
            check({tag, "_diff"}, Diff, lastExp.diff);
            check({tag, "_ovfl"}, 16'(lane_ovfl), 16'(lastExp.ovfl));
            check({tag, "_err"}, 16'(Error), 16'(lastExp.err));
            check({tag, "_busy"}, 16'(busy), 16'd0);
        end
    endtask

    // Count done pulses over a window of cycles.
    task automatic countDone(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) n++;
        end
    endtask

    initial begin
        int lat;
        int n;
        logic        rs;
        logic [15:0] ra;
        logic [15:0] rb;

        checks = 0;
        passes = 0;
        rst    = 1'b1;
        start  = 1'b0;
        sub    = 1'b0;
        A      = '0;
        B      = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_diff", Diff, 16'h0000);
        check("rst_ovfl", 16'(lane_ovfl), 16'd0);
        check("rst_err", 16'(Error), 16'd0);
        rst = 1'b0;
        tick();

        // Plain subtraction, latency and hold after DONE
        applyStimulus(1'b1, 16'h7654, 16'h1111);
        waitDone(lat);
        check("sub_latency", 16'(lat), 16'd4);
        checkOutput("sub_basic");
        check("sub_basic_const", Diff, 16'h6543);
        tick();
        check("done_one_cycle", 16'(done), 16'd0);
        check("hold_diff", Diff, lastExp.diff);
        check("hold_err", 16'(Error), 16'(lastExp.err));

        // Subtraction overflow in the top lane only
        applyStimulus(1'b1, 16'h8000, 16'h1000);
        waitDone(lat);
        checkOutput("sub_ovfl");
        check("sub_ovfl_const", 16'(lane_ovfl), 16'b1000);

        // Addition overflow in every lane
        applyStimulus(1'b0, 16'h7777, 16'h1111);
        waitDone(lat);
        checkOutput("add_ovfl");
        check("add_ovfl_const", Diff, 16'h8888);

        // Start re-pulsed and operands changed during RUN are ignored
        applyStimulus(1'b0, 16'h1234, 16'h4321);
        tick();
        start = 1'b1;
        sub   = 1'b1;
        A     = 16'hFFFF;
        B     = 16'h8888;
        tick();
        start = 1'b0;
        waitDone(lat);
        checkOutput("run_ignore");
        countDone(8, n);
        check("run_ignore_single_done", 16'(n), 16'd0);

        // A few random operations through the model
        for (int i = 0; i < 4; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            applyStimulus(rs, ra, rb);
            waitDone(lat);
            check("rand_latency", 16'(lat), 16'd4);
            checkOutput("rand");
        end

        // Reset while lane 2 is pending abandons the operation
        applyStimulus(1'b1, 16'h7654, 16'h1111);
        void'(sb.pop_back());
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_done", 16'(done), 16'd0);
        check("midrst_diff", Diff, 16'h0000);
        check("midrst_err", 16'(Error), 16'd0);
        countDone(10, n);
        check("midrst_no_done", 16'(n), 16'd0);

        // Start held high across DONE starts a back-to-back operation
        applyStimulus(1'b1, 16'h7654, 16'h1111);
        tick();
        start = 1'b1;
        sub   = 1'b0;
        A     = 16'h8888;
        B     = 16'h8888;
        waitDone(lat);
        checkOutput("b2b_first");
        sb.push_back(model(1'b0, 16'h8888, 16'h8888));
        tick();
        start = 1'b0;
        check("b2b_busy", 16'(busy), 16'd1);
        check("b2b_done_low", 16'(done), 16'd0);
        waitDone(lat);
        check("b2b_latency", 16'(lat), 16'd4);
        checkOutput("b2b_second");
        check("b2b_second_ovfl", 16'(lane_ovfl), 16'b1111);

        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
